// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave front end.
package i2c_pkg;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

    localparam logic I2C_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter.sv
// One I2C line: two-flop synchroniser followed by a consecutive-sample glitch filter.
module i2c_glitch_filter #(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw_in,
    output logic filt_out
);
    import i2c_pkg::*;

    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt_q;

    // Pads idle high, so the synchroniser powers up at the idle level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q1 <= I2C_IDLE_LEVEL;
            sync_q2 <= I2C_IDLE_LEVEL;
        end else begin
            sync_q1 <= raw_in;
            sync_q2 <= sync_q1;
        end
    end

    // Filtered level only follows after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            filt_out <= I2C_IDLE_LEVEL;
            cnt_q    <= '0;
        end else if (sync_q2 == filt_out) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_out <= sync_q2;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_line_monitor.sv
// I2C line conditioner: filtered SCL/SDA, SCL edge pulses, START/STOP pulses and bus ownership.
module i2c_line_monitor #(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_filt,
    output logic sda_filt,
    output logic rising_edge,
    output logic falling_edge,
    output logic start,
    output logic stop,
    output logic bus_busy
);
    import i2c_pkg::*;

    logic       scl_p;
    logic       sda_p;
    bus_state_t state_q;
    bus_state_t state_d;

    i2c_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
        .clk      (clk),
        .n_rst    (n_rst),
        .raw_in   (scl_in),
        .filt_out (scl_filt)
    );

    i2c_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
        .clk      (clk),
        .n_rst    (n_rst),
        .raw_in   (sda_in),
        .filt_out (sda_filt)
    );

    // START/STOP need SCL stable high, so an SCL change in the same cycle suppresses them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_p        <= I2C_IDLE_LEVEL;
            sda_p        <= I2C_IDLE_LEVEL;
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            start        <= 1'b0;
            stop         <= 1'b0;
        end else begin
            scl_p        <= scl_filt;
            sda_p        <= sda_filt;
            rising_edge  <= ~scl_p & scl_filt;
            falling_edge <= scl_p & ~scl_filt;
            start        <= scl_p & scl_filt & sda_p & ~sda_filt;
            stop         <= scl_p & scl_filt & ~sda_p & sda_filt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Repeated START holds BUS_BUSY; a stray STOP while idle changes nothing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (start) state_d = BUS_BUSY;
            BUS_BUSY: if (stop)  state_d = BUS_IDLE;
        endcase
    end

    assign bus_busy = (state_q == BUS_BUSY);

endmodule

// File: tb/tb_i2c_line_monitor.sv
// Randomised and directed bench for i2c_line_monitor against a windowed behavioural model.
module tb_i2c_line_monitor;

    localparam int unsigned FC = 4;

    logic clk    = 1'b0;
    logic n_rst  = 1'b0;
    logic scl_in = 1'b1;
    logic sda_in = 1'b1;
    logic scl_filt, sda_filt, rising_edge, falling_edge, start, stop, bus_busy;

    always #5 clk = ~clk;

    i2c_line_monitor #(.FILTER_CYCLES(FC)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .scl_filt     (scl_filt),
        .sda_filt     (sda_filt),
        .rising_edge  (rising_edge),
        .falling_edge (falling_edge),
        .start        (start),
        .stop         (stop),
        .bus_busy     (bus_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0;
    int s_rise, s_fall, s_start, s_stop;
    logic run_chk = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: sync = raw two clocks late; a filtered line flips once the last
    // FC synchronised samples all disagree with it; pulses follow the edge equations.
    logic m_s1, m_s2, m_t1, m_t2;
    logic m_sf, m_df, m_sp, m_dp;
    logic m_rise, m_fall, m_start, m_stop, m_busy;
    logic q_scl[$];
    logic q_sda[$];

    function automatic logic filt_next(input logic hist[$], input logic f);
        if (hist.size() < FC) return f;
        foreach (hist[i]) if (hist[i] == f) return f;
        return ~f;
    endfunction

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_t1 = 1'b1; m_t2 = 1'b1;
        m_sf = 1'b1; m_df = 1'b1; m_sp = 1'b1; m_dp = 1'b1;
        m_rise = 1'b0; m_fall = 1'b0; m_start = 1'b0; m_stop = 1'b0; m_busy = 1'b0;
        q_scl.delete();
        q_sda.delete();
    endtask

    always @(posedge clk) begin
        if (n_rst) begin
            if (m_start)     m_busy = 1'b1;
            else if (m_stop) m_busy = 1'b0;
            m_rise  = ~m_sp & m_sf;
            m_fall  = m_sp & ~m_sf;
            m_start = m_sp & m_sf & m_dp & ~m_df;
            m_stop  = m_sp & m_sf & ~m_dp & m_df;
            m_sp = m_sf;
            m_dp = m_df;
            q_scl.push_back(m_s2);
            if (q_scl.size() > FC) void'(q_scl.pop_front());
            q_sda.push_back(m_t2);
            if (q_sda.size() > FC) void'(q_sda.pop_front());
            m_sf = filt_next(q_scl, m_sf);
            m_df = filt_next(q_sda, m_df);
            m_s2 = m_s1; m_s1 = scl_in;
            m_t2 = m_t1; m_t1 = sda_in;
        end
    end

    // Every cycle: compare all outputs with the model and tally DUT pulses.
    always @(negedge clk) begin
        if (n_rst && run_chk) begin
            chk("scl_filt", int'(scl_filt), int'(m_sf));
            chk("sda_filt", int'(sda_filt), int'(m_df));
            chk("rising_edge", int'(rising_edge), int'(m_rise));
            chk("falling_edge", int'(falling_edge), int'(m_fall));
            chk("start", int'(start), int'(m_start));
            chk("stop", int'(stop), int'(m_stop));
            chk("bus_busy", int'(bus_busy), int'(m_busy));
            n_rise  += int'(rising_edge);
            n_fall  += int'(falling_edge);
            n_start += int'(start);
            n_stop  += int'(stop);
        end
    end

    task automatic hold(input logic s, input logic d, input int n);
        scl_in = s;
        sda_in = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_rise = n_rise; s_fall = n_fall; s_start = n_start; s_stop = n_stop;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_scl_filt"}, int'(scl_filt), 1);
        chk({tag, "_sda_filt"}, int'(sda_filt), 1);
        chk({tag, "_rising"}, int'(rising_edge), 0);
        chk({tag, "_falling"}, int'(falling_edge), 0);
        chk({tag, "_start"}, int'(start), 0);
        chk({tag, "_stop"}, int'(stop), 0);
        chk({tag, "_busy"}, int'(bus_busy), 0);
    endtask

    initial begin
        model_reset();
        #12;
        chk_reset_outputs("por");
        @(negedge clk);
        n_rst   = 1'b1;
        run_chk = 1'b1;
        snap();
        hold(1'b1, 1'b1, 20);
        chk("idle_pulses", n_rise + n_fall + n_start + n_stop - s_rise - s_fall - s_start - s_stop, 0);

        // SCL glitch one clock too short, then just long enough
        snap();
        hold(1'b0, 1'b1, FC - 1);
        hold(1'b1, 1'b1, 12);
        chk("glitch_short_fall", n_fall - s_fall, 0);
        chk("glitch_short_rise", n_rise - s_rise, 0);
        snap();
        hold(1'b0, 1'b1, FC);
        hold(1'b1, 1'b1, 12);
        chk("glitch_long_fall", n_fall - s_fall, 1);
        chk("glitch_long_rise", n_rise - s_rise, 1);

        // START then nine clock periods
        snap();
        hold(1'b1, 1'b0, 12);
        chk("start_count", n_start - s_start, 1);
        chk("start_busy", int'(bus_busy), 1);
        snap();
        repeat (9) begin
            hold(1'b0, 1'b0, 8);
            hold(1'b1, 1'b0, 8);
        end
        chk("byte_rise", n_rise - s_rise, 9);
        chk("byte_fall", n_fall - s_fall, 9);
        chk("byte_start", n_start - s_start, 0);
        chk("byte_stop", n_stop - s_stop, 0);

        // Repeated START keeps ownership
        hold(1'b0, 1'b0, 8);
        hold(1'b0, 1'b1, 8);
        snap();
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        chk("rstart_count", n_start - s_start, 1);
        chk("rstart_busy", int'(bus_busy), 1);

        // STOP releases the bus
        hold(1'b0, 1'b0, 8);
        hold(1'b1, 1'b0, 10);
        snap();
        hold(1'b1, 1'b1, 10);
        chk("stop_count", n_stop - s_stop, 1);
        chk("stop_busy", int'(bus_busy), 0);

        // SCL and SDA fall together: edge only
        snap();
        hold(1'b0, 1'b0, 10);
        chk("simul_fall", n_fall - s_fall, 1);
        chk("simul_start", n_start - s_start, 0);
        chk("simul_busy", int'(bus_busy), 0);
        hold(1'b0, 1'b1, 8);
        hold(1'b1, 1'b1, 10);

        // Reset mid-byte with SCL low
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 8);
        hold(1'b1, 1'b0, 8);
        hold(1'b0, 1'b0, 3);
        chk("pre_reset_busy", int'(bus_busy), 1);
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("mid_rst");
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        snap();
        repeat (6) begin
            @(negedge clk);
            chk("rel_early_fall", int'(falling_edge), 0);
        end
        @(negedge clk);
        chk("rel_fall_edge7", int'(falling_edge), 1);
        chk("rel_start_edge7", int'(start), 0);
        hold(1'b0, 1'b0, 6);
        chk("rel_fall_count", n_fall - s_fall, 1);
        chk("rel_start_count", n_start - s_start, 0);
        chk("rel_busy", int'(bus_busy), 0);

        // Random line activity, including sub-filter glitches
        repeat (300) begin
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        end
        hold(1'b1, 1'b1, 12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
